seg7_scan: RTL and testbench

Eight-digit multiplexed seven-segment display driver for the Nexys A7, sitting directly downstream of the 16-bit MIPS core in the FPGA top level. It consumes the core's program counter and ALU result and shows them as eight hexadecimal digits: PC on the left four, ALU result on the right four. Both values are snapshotted once per scan frame so the digits never tear. Each digit slot begins with a blanking interval to suppress ghosting.

---
 rtl/seg7_scan_if.sv | 21 ++
 rtl/seg7_scan.sv | 135 +++++++++++++
 tb/tb_seg7_scan.sv | 136 +++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Core-to-display bundle: snapshot sources and freeze in, multiplexed anode/cathode drive out.
// Pure wiring with no flow control; the display side samples the core values when it chooses.
interface seg7_scan_if;
  logic [15:0] pc_value;
  logic [15:0] alu_value;
  logic        freeze;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  modport master (
    output pc_value, alu_value, freeze,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  pc_value, alu_value, freeze,
    output an, seg, dp, frame_tick
  );
endinterface

// File: rtl/seg7_scan.sv
// 8-digit hex scan driver (PC left, ALU right). Outputs are registered one cycle after the scan state.
// No backpressure: core values are sampled only at frame start, and freeze skips that frame's capture.
module seg7_scan #(
  parameter int DIV_CYCLES   = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic        clk,
  input logic        reset_n,
  seg7_scan_if.slave disp
);

  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  typedef enum logic {
    PH_BLANK,
    PH_ON
  } phase_t;

  logic [CW-1:0] cnt;
  logic [2:0]    digit;
  logic [15:0]   pc_snap;
  logic [15:0]   alu_snap;
  logic          capture;
  phase_t        phase;

  logic [15:0]   sel_word;
  logic [3:0]    nibble;
  logic [7:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  logic [7:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic          frame_tick_q;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Slot timebase: cnt runs through one digit slot, digit advances on each wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      digit <= 3'd0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      digit <= digit + 3'd1;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

  assign capture = (cnt == '0) && (digit == 3'd0) && !disp.freeze;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_snap      <= 16'h0000;
      alu_snap     <= 16'h0000;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= capture;
      if (capture) begin
        pc_snap  <= disp.pc_value;
        alu_snap <= disp.alu_value;
      end
    end
  end

  // Leading part of each slot is dark so the previous digit's pattern cannot ghost onto the next anode.
  always_comb begin
    phase = (cnt < CNT_BLANK) ? PH_BLANK : PH_ON;
  end

  always_comb begin
    sel_word = digit[2] ? pc_snap : alu_snap;
    case (digit[1:0])
      2'd0:    nibble = sel_word[3:0];
      2'd1:    nibble = sel_word[7:4];
      2'd2:    nibble = sel_word[11:8];
      default: nibble = sel_word[15:12];
    endcase
  end

  always_comb begin
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (phase == PH_ON) begin
      an_d        = 8'hFF;
      an_d[digit] = 1'b0;
      seg_d       = hex_to_seg(nibble);
      dp_d        = (digit != 3'd4);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_q  <= 8'hFF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign disp.an         = an_q;
  assign disp.seg        = seg_q;
  assign disp.dp         = dp_q;
  assign disp.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: a DIV=8/BLANK=2 instance for the main sequence and a DIV=2/BLANK=1 instance.
module tb_seg7_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n;
  logic rst_b_n;

  seg7_scan_if ifa();
  seg7_scan_if ifb();

  seg7_scan #(.DIV_CYCLES(8), .BLANK_CYCLES(2)) dut_a (
    .clk     (clk),
    .reset_n (rst_a_n),
    .disp    (ifa)
  );

  seg7_scan #(.DIV_CYCLES(2), .BLANK_CYCLES(1)) dut_b (
    .clk     (clk),
    .reset_n (rst_b_n),
    .disp    (ifb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]      an_tbl  [8];
  logic [6:0]      hex_tbl [16];
  logic [7:0][6:0] f_abcd;   // pc 1234 / alu ABCD, indexed by digit
  logic [7:0][6:0] f_zero;   // pc 1234 / alu 0000
  logic [7:0][6:0] f_ffff;   // pc 1234 / alu FFFF
  logic [7:0][6:0] f_9abc;   // pc 9ABC / alu FFFF

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Packed as {an, seg, dp, frame_tick}.
  function automatic logic [16:0] obs_a();
    return {ifa.an, ifa.seg, ifa.dp, ifa.frame_tick};
  endfunction

  function automatic logic [16:0] obs_b();
    return {ifb.an, ifb.seg, ifb.dp, ifb.frame_tick};
  endfunction

  function automatic logic [16:0] exp_vec(input bit blank, input int d, input logic [6:0] s, input bit ft);
    if (blank)
      return {8'hFF, 7'h7F, 1'b1, ft};
    return {an_tbl[d], s, (d == 4) ? 1'b0 : 1'b1, ft};
  endfunction

  // One 64-cycle frame of dut_a, sampled after each edge; new inputs applied after local edge 20.
  task automatic run_frame(input string tag, input logic [7:0][6:0] segs, input bit exp_ft,
                           input logic [15:0] pc_mid, input logic [15:0] alu_mid, input bit frz_mid);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      chk($sformatf("%s_k%0d", tag, k), obs_a(),
          exp_vec((k % 8) < 2, k / 8, segs[k / 8], exp_ft && (k == 0)));
      if (k == 20) begin
        ifa.pc_value  = pc_mid;
        ifa.alu_value = alu_mid;
        ifa.freeze    = frz_mid;
      end
    end
  endtask

  initial begin
    an_tbl[0] = 8'hFE; an_tbl[1] = 8'hFD; an_tbl[2] = 8'hFB; an_tbl[3] = 8'hF7;
    an_tbl[4] = 8'hEF; an_tbl[5] = 8'hDF; an_tbl[6] = 8'hBF; an_tbl[7] = 8'h7F;
    hex_tbl[0]  = 7'h40; hex_tbl[1]  = 7'h79; hex_tbl[2]  = 7'h24; hex_tbl[3]  = 7'h30;
    hex_tbl[4]  = 7'h19; hex_tbl[5]  = 7'h12; hex_tbl[6]  = 7'h02; hex_tbl[7]  = 7'h78;
    hex_tbl[8]  = 7'h00; hex_tbl[9]  = 7'h10; hex_tbl[10] = 7'h08; hex_tbl[11] = 7'h03;
    hex_tbl[12] = 7'h46; hex_tbl[13] = 7'h21; hex_tbl[14] = 7'h06; hex_tbl[15] = 7'h0E;
    f_abcd = {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21};
    f_zero = {7'h79, 7'h24, 7'h30, 7'h19, 7'h40, 7'h40, 7'h40, 7'h40};
    f_ffff = {7'h79, 7'h24, 7'h30, 7'h19, 7'h0E, 7'h0E, 7'h0E, 7'h0E};
    f_9abc = {7'h10, 7'h08, 7'h03, 7'h46, 7'h0E, 7'h0E, 7'h0E, 7'h0E};

    rst_a_n       = 1'b0;
    rst_b_n       = 1'b0;
    ifa.pc_value  = 16'h1234;
    ifa.alu_value = 16'hABCD;
    ifa.freeze    = 1'b0;
    ifb.pc_value  = 16'h1234;
    ifb.alu_value = 16'hABCD;
    ifb.freeze    = 1'b0;

    repeat (5) @(negedge clk);
    chk("reset_hold", obs_a(), {8'hFF, 7'h7F, 1'b1, 1'b0});
    rst_a_n = 1'b1;

    // Full frame, then snapshot isolation (alu 0000 captured, FFFF applied mid-frame).
    run_frame("frame_abcd", f_abcd, 1'b1, 16'h1234, 16'h0000, 1'b0);
    run_frame("iso_zero",   f_zero, 1'b1, 16'h1234, 16'hFFFF, 1'b0);
    run_frame("iso_ffff",   f_ffff, 1'b1, 16'h5678, 16'hFFFF, 1'b1);
    // Freeze spans two capture edges while pc moves on.
    run_frame("frz_hold1",  f_ffff, 1'b0, 16'h9ABC, 16'hFFFF, 1'b1);
    run_frame("frz_hold2",  f_ffff, 1'b0, 16'h9ABC, 16'hFFFF, 1'b0);
    run_frame("frz_release", f_9abc, 1'b1, 16'h9ABC, 16'hFFFF, 1'b0);

    // Async reset between edges while digit 2 is lit.
    for (int k = 0; k < 20; k++) @(negedge clk);
    chk("pre_arst", obs_a(), {8'hFB, 7'h0E, 1'b1, 1'b0});
    #2 rst_a_n = 1'b0;
    #1 chk("arst_immediate", obs_a(), {8'hFF, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    chk("arst_held", obs_a(), {8'hFF, 7'h7F, 1'b1, 1'b0});
    rst_a_n = 1'b1;
    run_frame("arst_restart", f_9abc, 1'b1, 16'h9ABC, 16'h0000, 1'b0);

    // Decoder sweep: alu = 000v, one frame per value.
    for (int v = 0; v < 16; v++) begin
      run_frame($sformatf("dec%0d", v),
                {7'h10, 7'h08, 7'h03, 7'h46, 7'h40, 7'h40, 7'h40, hex_tbl[v]},
                1'b1, 16'h9ABC, 16'(v + 1), 1'b0);
    end

    // Minimum timing: one blank and one lit cycle per slot.
    rst_b_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk($sformatf("min_k%0d", k), obs_b(),
          exp_vec((k % 2) == 0, (k / 2) % 8, f_abcd[(k / 2) % 8], (k % 16) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
